sevenseg_scan_driver: RTL and testbench
=======================================

// Module: sevenseg_scan_driver
// PURPOSE
//  Time-multiplexed driver for the 4-digit common-anode 7-segment display. Consumes the packed
//  32-bit active-low pattern word from the number-to-7SD encoder and scans it onto the anode
//  and cathode pins. The active pattern is double-buffered so a display frame never tears.
//  Sits between the vending-machine datapath/encoder and the board display pins.
// PARAMETERS
//  REFRESH_DIV   default 100000  clk cycles per digit slot (>=2); 100 MHz -> 1 ms/digit
//  BLANK_CYCLES  default 1000    cycles at the start of each slot with all anodes off (anti-ghost); < REFRESH_DIV
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  en         in   1   1 = scan; 0 = display dark, scan counters held at slot 0
//  pat_in     in   32  packed pattern: [31:24] ones, [23:16] tens, [15:8] hundreds, [7:0] thousands
//  pat_load   in   1   1-cycle strobe: capture pat_in into the pending buffer
//  an         out  4   anodes, active-low; an[0] = ones (rightmost) ... an[3] = thousands
//  seg        out  7   cathodes {g,f,e,d,c,b,a}, active-low = pattern byte [7:1]
//  dp         out  1   decimal point, active-low = pattern byte [0]
//  frame_done out  1   1-cycle pulse at the end of digit slot 3
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset: an=4'hF, seg=7'h7F, dp=1, frame_done=0, active=pending=32'hFFFF_FFFF, pend_vld=0,
//    digit=0, cnt=0, state=BLANK. Reset mid-frame returns to this immediately.
//  - FSM per slot: BLANK (cnt 0..BLANK_CYCLES-1) -> SHOW (cnt BLANK_CYCLES..REFRESH_DIV-1) -> BLANK of next slot.
//  - cnt increments every enabled cycle; at REFRESH_DIV-1 it wraps to 0 and digit advances 0->1->2->3->0.
//  - BLANK: an=4'hF, seg=7'h7F, dp=1. SHOW: an = ~(1<<digit); seg/dp from active byte of digit.
//  - All outputs registered: 1-cycle latency from internal state to pins.
//  - pat_load: pending<=pat_in, pend_vld<=1; later loads before frame end overwrite (last wins).
//  - Frame boundary (cnt==REFRESH_DIV-1 && digit==3): frame_done pulses; if pend_vld,
//    active<=pending and pend_vld<=0. If pat_load coincides with the boundary, active<=pat_in
//    directly (bypass), pend_vld<=0.
//  - en=0: outputs dark next cycle, cnt/digit forced to 0/BLANK, no frame_done; pat_load still
//    accepted; on en=1 the pending pattern is promoted at once (treated as frame boundary).
//  - No arithmetic on pattern data; cnt width = $clog2(REFRESH_DIV).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: in SHOW, thousands slot is dark if its byte == 8'h81 ("0", dp off);
//    hundreds slot dark if thousands blanked and its byte == 8'h81; tens same rule; ones never blanked.
//    Dark slot: an stays 4'hF for the whole slot, timing unchanged.
//  Not defined: every slot shows its byte verbatim.
// TESTING (REFRESH_DIV=8, BLANK_CYCLES=2)
//  1 Reset, en=1, load 32'h3361_48F3 ("12.34") -> after first frame boundary an cycles E,D,B,7;
//    seg/dp = 33,61,48,F3 bytes split; each digit lit 6 cycles after 2 dark.
//  2 Frame timing -> frame_done pulses every 32 cycles, exactly 1 cycle wide.
//  3 Load A mid-frame then B before boundary -> B displayed next frame, A never shown; no change mid-frame.
//  4 Load on the exact boundary cycle -> new pattern visible in the following slot-0 SHOW.
//  5 Assert rst_n=0 during SHOW of digit 2 -> an=F, seg=7F, dp=1 same cycle, no clk needed.
//  6 LEADING_ZERO_BLANK_EN, load 32'h61_81_81_81 ("0003") -> only an[0] ever low, seg=7'h30;
//    32'h61_81_80_81 ("0.03") -> an[1], an[2] lit (dp low on hundreds), an[3] dark.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// Scans a double-buffered 32-bit active-low pattern onto a 4-digit common-anode 7-seg display.
// Each slot has a dark anti-ghost gap first. `define LEADING_ZERO_BLANK_EN darkens leading "0" digits.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] pat_in,
  input  logic        pat_load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;
  logic [31:0]   r_active;
  logic [31:0]   r_pending;
  logic          r_pend_vld;
  logic          r_en_d;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_done;

  logic [CW-1:0] w_cnt_nxt;
  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_promote;
  logic          w_dark;
  logic          w_lit;
  logic [7:0]    w_byte;

  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = en && w_slot_end && (r_digit == 2'd3);
  // Re-enabling acts as a frame boundary so a pattern loaded while dark appears at once.
  assign w_promote   = w_frame_end || (en && !r_en_d);

  always_comb begin
    w_byte = r_active[31:24];
    case (r_digit)
      2'd1:    w_byte = r_active[23:16];
      2'd2:    w_byte = r_active[15:8];
      2'd3:    w_byte = r_active[7:0];
      default: w_byte = r_active[31:24];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_blank_th;
  logic w_blank_hu;
  logic w_blank_te;
  assign w_blank_th = (r_active[7:0] == 8'h81);
  assign w_blank_hu = w_blank_th && (r_active[15:8] == 8'h81);
  assign w_blank_te = w_blank_hu && (r_active[23:16] == 8'h81);

  always_comb begin
    w_dark = 1'b0;
    case (r_digit)
      2'd3:    w_dark = w_blank_th;
      2'd2:    w_dark = w_blank_hu;
      2'd1:    w_dark = w_blank_te;
      default: w_dark = 1'b0;
    endcase
  end
`else
  assign w_dark = 1'b0;
`endif

  assign w_lit = en && (r_state == ST_SHOW) && !w_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_digit      <= 2'd0;
      r_active     <= 32'hFFFF_FFFF;
      r_pending    <= 32'hFFFF_FFFF;
      r_pend_vld   <= 1'b0;
      r_en_d       <= 1'b0;
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_en_d       <= en;
      r_frame_done <= w_frame_end;

      if (w_lit) begin
        r_an  <= ~(4'b0001 << r_digit);
        r_seg <= w_byte[7:1];
        r_dp  <= w_byte[0];
      end else begin
        r_an  <= 4'hF;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end

      if (!en) begin
        r_cnt   <= '0;
        r_digit <= 2'd0;
        r_state <= ST_BLANK;
      end else if (w_slot_end) begin
        r_cnt   <= '0;
        r_digit <= r_digit + 2'd1;
        r_state <= ST_BLANK;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_state <= (w_cnt_nxt >= CNT_SHOW) ? ST_SHOW : ST_BLANK;
      end

      if (pat_load) r_pending <= pat_in;
      if (w_promote) begin
        if (pat_load)        r_active <= pat_in;
        else if (r_pend_vld) r_active <= r_pending;
        r_pend_vld <= 1'b0;
      end else if (pat_load) begin
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2): tick-counter reference model plus literal frame checks.
module tb_sevenseg_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] pat_in;
  logic        pat_load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  sevenseg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pat_in(pat_in), .pat_load(pat_load),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int d);
    logic [31:0] s;
    s = w >> (8 * (3 - d));
    return s[7:0];
  endfunction

  function automatic bit lz_dark(input logic [31:0] w, input int d);
    bit dark;
    dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit read "0".
    if (d != 0) begin
      dark = 1'b1;
      for (int k = d; k <= 3; k++)
        if (byte_of(w, k) != 8'h81) dark = 1'b0;
    end
`endif
    return dark;
  endfunction

  // Reference model: one tick counter since enable; slot and in-slot position fall out of div/mod.
  logic [31:0] m_active, m_pending;
  bit          m_pvld, m_en_prev;
  int          m_tick, m_slot, m_pos;
  bit          m_bound, m_lit;
  logic [7:0]  m_byte;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 32'hFFFF_FFFF; m_pending = 32'hFFFF_FFFF;
      m_pvld = 1'b0; m_en_prev = 1'b0; m_tick = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      m_slot  = (m_tick / RD) % 4;
      m_pos   = m_tick % RD;
      m_byte  = byte_of(m_active, m_slot);
      m_bound = en && (m_tick % (4 * RD) == 4 * RD - 1);
      m_lit   = en && (m_pos >= BC) && !lz_dark(m_active, m_slot);
      e_an    = m_lit ? ~(4'b0001 << m_slot) : 4'hF;
      e_seg   = m_lit ? m_byte[7:1] : 7'h7F;
      e_dp    = m_lit ? m_byte[0] : 1'b1;
      e_fd    = m_bound;
      if (m_bound || (en && !m_en_prev)) begin
        if (pat_load)    m_active = pat_in;
        else if (m_pvld) m_active = m_pending;
        m_pvld = 1'b0;
      end else if (pat_load) begin
        m_pending = pat_in;
        m_pvld    = 1'b1;
      end
      m_en_prev = en;
      m_tick    = en ? m_tick + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("cyc_an", an, e_an);
      chk("cyc_seg", seg, e_seg);
      chk("cyc_dp", dp, e_dp);
      chk("cyc_frame_done", frame_done, e_fd);
    end
  end

  // Frame capture: index 0..3 = digit lit, 4 = all dark, 5 = illegal anode code.
  int         lit_cnt [6];
  logic [6:0] seg_of  [4];
  logic       dp_of   [4];

  task automatic scan_frame();
    int idx;
    for (int i = 0; i < 6; i++) lit_cnt[i] = 0;
    for (int i = 0; i < 4; i++) begin seg_of[i] = 7'h00; dp_of[i] = 1'b0; end
    repeat (4 * RD) begin
      @(negedge clk);
      case (an)
        4'hE:    idx = 0;
        4'hD:    idx = 1;
        4'hB:    idx = 2;
        4'h7:    idx = 3;
        4'hF:    idx = 4;
        default: idx = 5;
      endcase
      lit_cnt[idx]++;
      if (idx < 4) begin seg_of[idx] = seg; dp_of[idx] = dp; end
    end
  endtask

  task automatic check_frame(input string nm, input logic [31:0] p);
    logic [7:0] b;
    for (int d = 0; d < 4; d++) begin
      b = byte_of(p, d);
      chk({nm, "_litcnt"}, lit_cnt[d], RD - BC);
      chk({nm, "_seg"}, seg_of[d], b[7:1]);
      chk({nm, "_dp"}, dp_of[d], b[0]);
    end
    chk({nm, "_darkcnt"}, lit_cnt[4], 4 * BC);
    chk({nm, "_badan"}, lit_cnt[5], 0);
  endtask

  task automatic wait_fd(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 100);
    chk(nm, frame_done, 1'b1);
  endtask

  task automatic load(input logic [31:0] p);
    pat_in = p; pat_load = 1'b1;
    @(negedge clk);
    pat_load = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] pa, pb, pc, pd;
    pa = 32'h1111_1111; pb = 32'h9F25_0D99; pc = 32'h0344_A6C2; pd = 32'h0CF2_A460;
    rst_n = 1'b0; en = 1'b0; pat_in = '0; pat_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1; en = 1'b1; chk_on = 1'b1;

    // "12.34": visible only after the first boundary
    @(negedge clk);
    load(32'h3361_48F3);
    wait_fd("fd_first");
    scan_frame();
    check_frame("f1234", 32'h3361_48F3);
    chk("lit_seg_ones", seg_of[0], 7'h19);
    chk("lit_seg_tens", seg_of[1], 7'h30);
    chk("lit_seg_hund", seg_of[2], 7'h24);
    chk("lit_seg_thou", seg_of[3], 7'h79);
    chk("lit_dp_hund", dp_of[2], 1'b0);
    chk("lit_dp_thou", dp_of[3], 1'b1);

    // frame_done period and width
    n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 100);
    chk("fd_period", n, 4 * RD);
    @(negedge clk);
    chk("fd_width", frame_done, 1'b0);

    // two loads in one frame: last wins, nothing changes mid-frame
    repeat (8) @(negedge clk);
    load(pa);
    repeat (6) @(negedge clk);
    load(pb);
    wait_fd("fd_after_ab");
    scan_frame();
    check_frame("fB", pb);

    // load on the boundary cycle itself bypasses the pending buffer
    repeat (4 * RD - 1) @(negedge clk);
    pat_in = pc; pat_load = 1'b1;
    @(negedge clk);
    pat_load = 1'b0;
    chk("fd_at_bypass", frame_done, 1'b1);
    scan_frame();
    check_frame("fC", pc);

    // async reset during SHOW of digit 2
    repeat (21) @(negedge clk);
    chk("pre_rst_an", an, 4'hB);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fd("fd_post_rst");
    scan_frame();
    check_frame("fRst", 32'hFFFF_FFFF);

    // disable goes dark; a load while dark is promoted as soon as scanning resumes
    repeat (13) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dis_an", an, 4'hF);
    load(pd);
    repeat (4) @(negedge clk);
    chk("dis_an_hold", an, 4'hF);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reen_an", an, 4'hE);
    chk("reen_seg", seg, 7'h06);
    chk("reen_dp", dp, 1'b0);

    // random loads and enable toggles against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      pat_in   = $urandom;
      pat_load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
    end
    pat_load = 1'b0; en = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
